// File: rtl/arch_defs_pkg.sv
`default_nettype none
// ============================================================================
// Module   : arch_defs_pkg
// Purpose  : Shared architecture definitions: program loader sync bytes and
//            loader FSM state encoding.
// Revision : 1.0 - initial release
// ============================================================================
package arch_defs_pkg;

  // Frame opener and end-of-load command bytes
  localparam logic [7:0] LOADER_SYNC_FRAME = 8'hA5;
  localparam logic [7:0] LOADER_SYNC_END   = 8'h5A;

  typedef enum logic [2:0] {
    LD_IDLE    = 3'd0,
    LD_ADDR_HI = 3'd1,
    LD_ADDR_LO = 3'd2,
    LD_LEN     = 3'd3,
    LD_DATA    = 3'd4,
    LD_CSUM    = 3'd5,
    LD_DONE    = 3'd6,
    LD_ERROR   = 3'd7
  } loader_state_t;

  // True in the states that sit inside a frame, where the idle timeout runs
  function automatic logic in_frame(input loader_state_t s);
    return (s == LD_ADDR_HI) || (s == LD_ADDR_LO) || (s == LD_LEN) ||
           (s == LD_DATA)    || (s == LD_CSUM);
  endfunction

endpackage
`default_nettype wire

// File: rtl/loader_timeout.sv
`default_nettype none
// ============================================================================
// Module   : loader_timeout
// Purpose  : Idle-cycle counter. 'expired' is asserted combinationally on the
//            cycle whose clock edge would be the TIMEOUT_CYCLES-th consecutive
//            enabled cycle, so the owner can act on that same edge.
//            TIMEOUT_CYCLES = 0 disables the counter.
// Revision : 1.0 - initial release
// ============================================================================
module loader_timeout #(
  parameter int TIMEOUT_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  generate
    if (TIMEOUT_CYCLES > 0) begin : g_count
      localparam int            CW     = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
      localparam logic [CW-1:0] C_LAST = CW'(TIMEOUT_CYCLES - 1);

      logic [CW-1:0] r_cnt;

      // Count enabled cycles; clear has priority over counting
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          r_cnt <= '0;
        end else if (clear) begin
          r_cnt <= '0;
        end else if (enable) begin
          r_cnt <= r_cnt + 1'b1;
        end
      end

      assign expired = enable && !clear && (r_cnt == C_LAST);
    end else begin : g_disabled
      logic w_unused;
      assign w_unused = &{1'b0, clk, reset, clear, enable};
      assign expired  = 1'b0;
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/program_loader.sv
`default_nettype none
// ============================================================================
// Module   : program_loader
// Purpose  : Boot-time loader. Parses A5-framed records from a byte stream,
//            writes their payload into memory one byte per cycle, verifies
//            an additive checksum and releases the CPU on a 5A command.
// Revision : 1.0 - initial release
// ============================================================================
module program_loader
  import arch_defs_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1_000_000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_wdata,
  output logic        cpu_hold,
  output logic        load_done,
  output logic        load_error,
  output logic [7:0]  frame_count
);

  loader_state_t r_state;
  logic [15:0]   r_addr;      // address of the next data byte
  logic [7:0]    r_sum;       // running 8-bit sum since addr_hi
  logic [8:0]    r_remain;    // data bytes still expected (1..256)

  logic          w_accept;
  logic          w_in_frame;
  logic          w_expired;
  logic [7:0]    w_sum_next;

  assign w_accept   = rx_valid && rx_ready;
  assign w_in_frame = in_frame(r_state);
  assign w_sum_next = r_sum + rx_data;

  loader_timeout #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_timeout (
    .clk     (clk),
    .reset   (reset),
    .clear   (w_accept || !w_in_frame),
    .enable  (w_in_frame && !w_accept),
    .expired (w_expired)
  );

  // Frame parser FSM with all outputs registered; rx_ready depends only on state
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= LD_IDLE;
      r_addr      <= 16'h0000;
      r_sum       <= 8'h00;
      r_remain    <= 9'd0;
      rx_ready    <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= 16'h0000;
      mem_wdata   <= 8'h00;
      cpu_hold    <= 1'b1;
      load_done   <= 1'b0;
      load_error  <= 1'b0;
      frame_count <= 8'h00;
    end else begin
      mem_we <= 1'b0;
      case (r_state)
        LD_IDLE: begin
          rx_ready <= 1'b1;
          if (w_accept) begin
            if (rx_data == LOADER_SYNC_FRAME) begin
              r_state <= LD_ADDR_HI;
            end else if (rx_data == LOADER_SYNC_END) begin
              r_state   <= LD_DONE;
              rx_ready  <= 1'b0;
              cpu_hold  <= 1'b0;
              load_done <= 1'b1;
            end
          end
        end
        LD_ADDR_HI: begin
          if (w_accept) begin
            r_addr[15:8] <= rx_data;
            r_sum        <= rx_data;
            r_state      <= LD_ADDR_LO;
          end
        end
        LD_ADDR_LO: begin
          if (w_accept) begin
            r_addr[7:0] <= rx_data;
            r_sum       <= w_sum_next;
            r_state     <= LD_LEN;
          end
        end
        LD_LEN: begin
          if (w_accept) begin
            // A length byte of zero encodes a full 256-byte payload
            r_remain <= (rx_data == 8'h00) ? 9'd256 : {1'b0, rx_data};
            r_sum    <= w_sum_next;
            r_state  <= LD_DATA;
          end
        end
        LD_DATA: begin
          if (w_accept) begin
            mem_we    <= 1'b1;
            mem_addr  <= r_addr;
            mem_wdata <= rx_data;
            r_addr    <= r_addr + 16'h0001;   // wraps FFFF -> 0000
            r_sum     <= w_sum_next;
            r_remain  <= r_remain - 9'd1;
            if (r_remain == 9'd1) begin
              r_state <= LD_CSUM;
            end
          end
        end
        LD_CSUM: begin
          if (w_accept) begin
            if (w_sum_next == 8'h00) begin
              r_state <= LD_IDLE;
              if (frame_count != 8'hFF) begin
                frame_count <= frame_count + 8'h01;
              end
            end else begin
              r_state    <= LD_ERROR;
              rx_ready   <= 1'b0;
              load_error <= 1'b1;
            end
          end
        end
        LD_DONE: begin
          rx_ready <= 1'b0;
        end
        default: begin
          rx_ready <= 1'b0;
        end
      endcase

      // An in-frame stall overrides everything; no byte is accepted then
      if (w_expired) begin
        r_state    <= LD_ERROR;
        rx_ready   <= 1'b0;
        load_error <= 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_program_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_program_loader
// Purpose  : Directed self-checking bench for program_loader.
// Revision : 1.0 - initial release
// ============================================================================
module tb_program_loader;

  logic        clk;
  logic        reset;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        cpu_hold;
  logic        load_done;
  logic        load_error;
  logic [7:0]  frame_count;

  int n_total = 0;
  int n_bad   = 0;
  int cyc     = 0;

  typedef struct {
    logic [15:0] a;
    logic [7:0]  d;
    int          c;
  } wr_t;
  wr_t wq[$];

  program_loader #(
    .TIMEOUT_CYCLES (16)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .rx_ready    (rx_ready),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .cpu_hold    (cpu_hold),
    .load_done   (load_done),
    .load_error  (load_error),
    .frame_count (frame_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Record every write strobe, sampled mid-cycle
  always @(negedge clk) begin
    if (mem_we) wq.push_back('{mem_addr, mem_wdata, cyc});
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Present one byte and hold it until the loader takes it (bounded)
  task automatic send_byte(input logic [7:0] b);
    int guard;
    guard    = 0;
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    while (!rx_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (!rx_ready) check("rx_ready_wait", {31'd0, rx_ready}, 32'd1);
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
  endtask

  task automatic send_bytes(input logic [7:0] bs[$]);
    foreach (bs[i]) send_byte(bs[i]);
  endtask

  // Hold reset, check every output's reset value, then release
  task automatic do_reset(input string tag);
    rx_valid = 1'b0;
    reset    = 1'b0;
    repeat (2) @(negedge clk);
    check({tag, "_rst_ready"}, {31'd0, rx_ready}, 32'd0);
    check({tag, "_rst_we"},    {31'd0, mem_we}, 32'd0);
    check({tag, "_rst_addr"},  {16'd0, mem_addr}, 32'h0000);
    check({tag, "_rst_wdata"}, {24'd0, mem_wdata}, 32'h00);
    check({tag, "_rst_hold"},  {31'd0, cpu_hold}, 32'd1);
    check({tag, "_rst_done"},  {31'd0, load_done}, 32'd0);
    check({tag, "_rst_err"},   {31'd0, load_error}, 32'd0);
    check({tag, "_rst_fc"},    {24'd0, frame_count}, 32'd0);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check({tag, "_ready_rise"}, {31'd0, rx_ready}, 32'd1);
  endtask

  initial begin
    int nbad4;
    reset    = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    repeat (2) @(posedge clk);
    #1;

    // 1: good frame, then end-of-load command
    do_reset("t1");
    wq.delete();
    send_bytes('{8'hA5, 8'hF0, 8'h00, 8'h03, 8'h11, 8'h22, 8'h33, 8'hA7});
    check("t1_fc",     {24'd0, frame_count}, 32'd1);
    check("t1_err",    {31'd0, load_error}, 32'd0);
    check("t1_hold",   {31'd0, cpu_hold}, 32'd1);
    check("t1_nwr",    wq.size(), 32'd3);
    check("t1_w0",     {8'd0, wq[0].a, wq[0].d}, 32'h00F00011);
    check("t1_w1",     {8'd0, wq[1].a, wq[1].d}, 32'h00F00122);
    check("t1_w2",     {8'd0, wq[2].a, wq[2].d}, 32'h00F00233);
    check("t1_consec", wq[2].c - wq[0].c, 32'd2);
    send_byte(8'h5A);
    check("t1_hold_rel", {31'd0, cpu_hold}, 32'd0);
    check("t1_done",     {31'd0, load_done}, 32'd1);
    check("t1_ready_lo", {31'd0, rx_ready}, 32'd0);

    // 2: address wrap
    do_reset("t2");
    wq.delete();
    send_bytes('{8'hA5, 8'hFF, 8'hFF, 8'h02, 8'hAA, 8'hBB, 8'h9B});
    check("t2_nwr", wq.size(), 32'd2);
    check("t2_w0",  {8'd0, wq[0].a, wq[0].d}, 32'h00FFFFAA);
    check("t2_w1",  {8'd0, wq[1].a, wq[1].d}, 32'h000000BB);
    check("t2_fc",  {24'd0, frame_count}, 32'd1);

    // 3: bad checksum (continues from t2 without reset)
    wq.delete();
    send_bytes('{8'hA5, 8'hF0, 8'h00, 8'h03, 8'h11, 8'h22, 8'h33, 8'h00});
    check("t3_nwr",   wq.size(), 32'd3);
    check("t3_w2",    {8'd0, wq[2].a, wq[2].d}, 32'h00F00233);
    check("t3_err",   {31'd0, load_error}, 32'd1);
    check("t3_ready", {31'd0, rx_ready}, 32'd0);
    check("t3_hold",  {31'd0, cpu_hold}, 32'd1);
    check("t3_fc",    {24'd0, frame_count}, 32'd1);
    rx_data  = 8'h5A;
    rx_valid = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    rx_valid = 1'b0;
    check("t3_end_ignored", {31'd0, load_done}, 32'd0);
    check("t3_hold_kept",   {31'd0, cpu_hold}, 32'd1);

    // 4: junk in IDLE, then a 256-byte frame (len = 0)
    do_reset("t4");
    wq.delete();
    send_bytes('{8'h00, 8'hFF});
    @(posedge clk);
    #1;
    check("t4_junk_nwr",   wq.size(), 32'd0);
    check("t4_junk_ready", {31'd0, rx_ready}, 32'd1);
    send_bytes('{8'hA5, 8'h10, 8'h00, 8'h00});
    for (int i = 0; i < 256; i++) send_byte(8'(i));
    send_byte(8'h70);
    check("t4_nwr", wq.size(), 32'd256);
    nbad4 = 0;
    foreach (wq[i]) begin
      if (wq[i].a !== 16'(16'h1000 + i) || wq[i].d !== 8'(i)) nbad4++;
    end
    check("t4_content", nbad4, 32'd0);
    check("t4_fc",      {24'd0, frame_count}, 32'd1);
    check("t4_err",     {31'd0, load_error}, 32'd0);

    // 5: timeout only inside a frame
    do_reset("t5");
    repeat (24) @(posedge clk);
    #1;
    check("t5_idle_noerr", {31'd0, load_error}, 32'd0);
    send_bytes('{8'hA5, 8'hF0});
    repeat (15) @(posedge clk);
    #1;
    check("t5_err_15", {31'd0, load_error}, 32'd0);
    @(posedge clk);
    #1;
    check("t5_err_16",  {31'd0, load_error}, 32'd1);
    check("t5_ready",   {31'd0, rx_ready}, 32'd0);
    check("t5_hold",    {31'd0, cpu_hold}, 32'd1);

    // 6: reset mid-frame, then a fresh frame
    do_reset("t6a");
    send_bytes('{8'hA5, 8'hF0, 8'h00, 8'h02, 8'h11});
    do_reset("t6b");
    wq.delete();
    send_bytes('{8'hA5, 8'hF0, 8'h00, 8'h03, 8'h11, 8'h22, 8'h33, 8'hA7});
    check("t6_nwr", wq.size(), 32'd3);
    check("t6_w0",  {8'd0, wq[0].a, wq[0].d}, 32'h00F00011);
    check("t6_fc",  {24'd0, frame_count}, 32'd1);
    check("t6_err", {31'd0, load_error}, 32'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
